// File: rtl/par_to_ser_feeder.sv
// Parallel-word to serial-bit feeder for the Mealy sequence detector.
// One-entry hold register lets consecutive words stream with no idle bit.
module par_to_ser_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             x_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             x_last_q, x_last_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic [WIDTH-1:0] shift_next;
    logic             head_d;

    // A free hold slot is the only thing gating acceptance.
    assign load_ready = ~hold_full_q;
    assign accept     = load_valid & ~hold_full_q;

    // Advance the shifter so the next bit to send sits at the output end.
    assign shift_next = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, shift_q[WIDTH-1:1]};

    // Next-state: word loading, bit advance and end-of-word handover.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = load_data;
                    cnt_d   = LAST;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    shift_d = shift_next;
                    cnt_d   = cnt_q - CW'(1);
                    if (accept) begin
                        hold_d      = load_data;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // load_ready is low here, so no new word can race in.
                    shift_d     = hold_q;
                    cnt_d       = LAST;
                    hold_full_d = 1'b0;
                end else if (accept) begin
                    shift_d = load_data;
                    cnt_d   = LAST;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs reflect the bit that will be on x after the edge.
    always_comb begin
        head_d    = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
        x_valid_d = (state_d == SHIFT);
        x_last_d  = x_valid_d & (cnt_d == '0);
        x_d       = x_valid_d & head_d;
        busy_d    = x_valid_d | hold_full_d;
    end

    // All state; reset drops any word in flight and empties the hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            x_q         <= 1'b0;
            x_valid_q   <= 1'b0;
            x_last_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            x_q         <= x_d;
            x_valid_q   <= x_valid_d;
            x_last_q    <= x_last_d;
            busy_q      <= busy_d;
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign x_last  = x_last_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_par_to_ser_feeder.sv
// Bench for par_to_ser_feeder: MSB-first and LSB-first instances share stimulus
// and are checked each cycle against a bit-queue model.
module tb_par_to_ser_feeder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         load_valid = 1'b0;

    logic rdy_m, x_m, xv_m, xl_m, busy_m;
    logic rdy_l, x_l, xv_l, xl_l, busy_l;

    int checks = 0;
    int errors = 0;

    // Pending bits in send order, each entry {last, bit}; front is on x now.
    bit [1:0] qm[$];
    bit [1:0] ql[$];

    logic [63:0] cap_m, cap_l;
    int cnt_m, cnt_l, cyc, first_m, last_m;

    always #5 clk = ~clk;

    par_to_ser_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .load_data(load_data),
        .load_valid(load_valid), .load_ready(rdy_m), .x(x_m),
        .x_valid(xv_m), .x_last(xl_m), .busy(busy_m)
    );

    par_to_ser_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .load_data(load_data),
        .load_valid(load_valid), .load_ready(rdy_l), .x(x_l),
        .x_valid(xv_l), .x_last(xl_l), .busy(busy_l)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge of the model: the shown bit is consumed, an accepted
    // word appends its bits. At most two words fit (shifter + hold).
    task automatic model_edge(input logic v, input logic [W-1:0] d);
        bit acc;
        acc = v && (qm.size() <= W);
        if (qm.size() > 0) qm.delete(0);
        if (ql.size() > 0) ql.delete(0);
        if (acc) begin
            for (int i = 0; i < W; i++) begin
                qm.push_back({i == W - 1, d[W-1-i]});
                ql.push_back({i == W - 1, d[i]});
            end
        end
    endtask

    task automatic compare();
        bit [1:0] em, el;
        int nm, nl;
        nm = qm.size();
        nl = ql.size();
        em = (nm > 0) ? qm[0] : 2'b00;
        el = (nl > 0) ? ql[0] : 2'b00;
        chk("x_valid_msb", xv_m, nm > 0);
        chk("x_msb", x_m, em[0]);
        chk("x_last_msb", xl_m, em[1]);
        chk("busy_msb", busy_m, nm > 0);
        chk("ready_msb", rdy_m, nm <= W);
        chk("x_valid_lsb", xv_l, nl > 0);
        chk("x_lsb", x_l, el[0]);
        chk("x_last_lsb", xl_l, el[1]);
        chk("busy_lsb", busy_l, nl > 0);
        chk("ready_lsb", rdy_l, nl <= W);
        cyc++;
        if (xv_m === 1'b1) begin
            cap_m = {cap_m[62:0], x_m};
            cnt_m++;
            if (first_m < 0) first_m = cyc;
            last_m = cyc;
        end
        if (xv_l === 1'b1) begin
            cap_l = {cap_l[62:0], x_l};
            cnt_l++;
        end
    endtask

    task automatic clear_cap();
        cap_m = '0;
        cap_l = '0;
        cnt_m = 0;
        cnt_l = 0;
        first_m = -1;
        last_m = -1;
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d);
        load_valid = v;
        load_data  = d;
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        compare();
        load_valid = 1'b0;
        load_data  = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0);
    endtask

    initial begin
        cyc = 0;
        clear_cap();

        // Reset state
        @(negedge clk);
        chk("rst_x", x_m, 0);
        chk("rst_x_valid", xv_m, 0);
        chk("rst_x_last", xl_m, 0);
        chk("rst_busy", busy_m, 0);
        chk("rst_ready", rdy_m, 1);
        compare();
        reset = 1'b1;

        // Single word, MSB first
        clear_cap();
        cycle(1'b1, 8'b1011_0010);
        chk("t2_first_valid", xv_m, 1);
        chk("t2_first_bit", x_m, 1);
        idle(10);
        chk("t2_bits", cap_m[7:0], 8'hB2);
        chk("t2_count", cnt_m, 8);
        chk("t2_lsb_bits", cap_l[7:0], 8'h4D);
        chk("t2_idle_valid", xv_m, 0);

        // Back-to-back through the hold register
        clear_cap();
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h3C);
        chk("t3_ready_low", rdy_m, 0);
        chk("t3_busy", busy_m, 1);
        idle(6);
        chk("t3_last_of_first", xl_m, 1);
        chk("t3_ready_still_low", rdy_m, 0);
        idle(1);
        chk("t3_ready_back", rdy_m, 1);
        idle(10);
        chk("t3_bits", cap_m[15:0], 16'hA53C);
        chk("t3_count", cnt_m, 16);
        chk("t3_contiguous", last_m - first_m + 1, 16);

        // Bypass load in the x_last cycle with hold empty
        clear_cap();
        cycle(1'b1, 8'h55);
        idle(7);
        chk("t4_in_last", xl_m, 1);
        chk("t4_ready", rdy_m, 1);
        cycle(1'b1, 8'hF0);
        chk("t4_bypass_valid", xv_m, 1);
        chk("t4_bypass_bit", x_m, 1);
        chk("t4_bypass_ready", rdy_m, 1);
        idle(10);
        chk("t4_bits", cap_m[15:0], 16'h55F0);
        chk("t4_count", cnt_m, 16);
        chk("t4_contiguous", last_m - first_m + 1, 16);

        // LSB-first ordering
        clear_cap();
        cycle(1'b1, 8'b0000_0011);
        idle(10);
        chk("t5_lsb_bits", cap_l[7:0], 8'hC0);
        chk("t5_lsb_count", cnt_l, 8);
        chk("t5_msb_bits", cap_m[7:0], 8'h03);

        // Reset mid-word, then a fresh word
        clear_cap();
        cycle(1'b1, 8'hFF);
        idle(2);
        chk("t6_busy_mid", busy_m, 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_x", x_m, 0);
        chk("t6_rst_x_valid", xv_m, 0);
        chk("t6_rst_x_last", xl_m, 0);
        chk("t6_rst_busy", busy_m, 0);
        chk("t6_rst_ready", rdy_m, 1);
        chk("t6_rst_x_valid_lsb", xv_l, 0);
        chk("t6_rst_busy_lsb", busy_l, 0);
        qm.delete();
        ql.delete();
        compare();
        @(negedge clk);
        reset = 1'b1;
        clear_cap();
        cycle(1'b1, 8'h81);
        idle(10);
        chk("t6_bits", cap_m[7:0], 8'h81);
        chk("t6_count", cnt_m, 8);
        chk("t6_lsb_bits", cap_l[7:0], 8'h81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
